// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM/operator enums, result type and saturating arithmetic for the calculator
package calc_pkg;
  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_OP = 2'd2, S_RES = 2'd3} state_t;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_t;
  typedef logic signed [4:0] result_t;
  typedef struct packed {
    logic    ovf;
    result_t res;
  } calc_t;
  localparam logic signed [5:0] RES_MAX = 6'sd15;
  localparam logic signed [5:0] RES_MIN = -6'sd16;
  function automatic calc_t calc_sat(input logic [3:0] a, input logic [3:0] b, input op_t op);
    logic signed [5:0] v;
    calc_t c;
    v = (op == OP_SUB) ? $signed({2'b00, a}) - $signed({2'b00, b})
                       : $signed({2'b00, a}) + $signed({2'b00, b});
    c.ovf = (v > RES_MAX) || (v < RES_MIN);
    c.res = (v > RES_MAX) ? RES_MAX[4:0] : (v < RES_MIN) ? RES_MIN[4:0] : v[4:0];
    return c;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and registered one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0]       r_sync;
  logic             r_level, r_press;
  logic [CNT_W-1:0] r_cnt;
  // the flip lands on the DEBOUNCE_CYCLES-th consecutive differing sample
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) r_cnt <= '0;
      else if (r_cnt == CNT_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
        r_press <= ~r_level;
      end else r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign o_press = r_press;
endmodule

// File: rtl/calc_input_ctrl.sv
// calc_input_ctrl: debounced buttons sequencing operand/operator entry and a saturated 5-bit signed result
module calc_input_ctrl
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_op,
  input  logic       btn_mode,
  output logic [3:0] operand1,
  output logic [3:0] operand2,
  output logic [4:0] result,
  output logic       result_valid,
  output logic       overflow,
  output logic       op_sel,
  output logic [1:0] state,
  output logic       mode_change
);
  state_t     r_state, w_state_n;
  op_t        r_op, w_op_n;
  logic [3:0] r_a, r_b, w_a_n, w_b_n;
  result_t    r_res, w_res_n;
  logic       r_ovf, r_valid, w_ovf_n, w_valid_n;
  logic       w_enter, w_op;
  calc_t      w_calc;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .reset(reset), .i_btn(btn_enter), .o_press(w_enter));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_op (
    .clk(clk), .reset(reset), .i_btn(btn_op), .o_press(w_op));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .i_btn(btn_mode), .o_press(mode_change));
  assign w_calc = calc_sat(r_a, r_b, r_op);
  // enter takes priority over a coincident op press in S_OP
  always_comb begin
    w_state_n = r_state;
    w_op_n    = r_op;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_res_n   = r_res;
    w_ovf_n   = r_ovf;
    w_valid_n = r_valid;
    case (r_state)
      S_A:  if (w_enter) begin
        w_a_n     = sw;
        w_state_n = S_B;
      end
      S_B:  if (w_enter) begin
        w_b_n     = sw;
        w_state_n = S_OP;
      end
      S_OP: if (w_enter) begin
        w_res_n   = w_calc.res;
        w_ovf_n   = w_calc.ovf;
        w_valid_n = 1'b1;
        w_state_n = S_RES;
      end else if (w_op) w_op_n = op_t'(~r_op);
      S_RES: if (w_enter) begin
        w_a_n     = '0;
        w_b_n     = '0;
        w_res_n   = '0;
        w_ovf_n   = 1'b0;
        w_valid_n = 1'b0;
        w_state_n = S_A;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_A;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_op    <= w_op_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_res   <= w_res_n;
      r_ovf   <= w_ovf_n;
      r_valid <= w_valid_n;
    end
  end
  assign operand1     = r_a;
  assign operand2     = r_b;
  assign result       = r_res;
  assign overflow     = r_ovf;
  assign result_valid = r_valid;
  assign op_sel       = r_op;
  assign state        = r_state;
endmodule
